ram_to_notes: RTL and testbench

- Playback engine: reads the recorded song RAM (16-bit entries, 7-bit address) and drives up to 8 simultaneous voices of 6-bit notes to the synth.
- Consumer side of the recording path: it decodes the same entry format that the recorder writes.
- Runs only while master_state == 2'b10 (PLAY).
- Reports start and finish pulses to lip_synth_master.

---
 rtl/ram_to_notes_pkg.sv | 65 ++++++
 rtl/ram_to_notes_voice_timer.sv | 39 +++
 rtl/ram_to_notes.sv | 171 +++++++++++++++++
 tb/tb_ram_to_notes.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_to_notes_pkg.sv
// Shared definitions for the player piano song format.
// The recorder and this playback engine both decode entries through these
// field positions and helpers, so writer and reader cannot drift apart.
package ram_to_notes_pkg;

  // master_state encodings
  localparam logic [1:0] MS_IDLE   = 2'b00;
  localparam logic [1:0] MS_RECORD = 2'b01;
  localparam logic [1:0] MS_PLAY   = 2'b10;

  // Song RAM geometry
  localparam int ENTRY_W = 16;
  localparam int ADDR_W  = 7;

  // Entry field positions
  localparam int ENTRY_HOLD_BIT = 15;
  localparam int VOICE_MSB      = 14;
  localparam int VOICE_LSB      = 12;
  localparam int NOTE_MSB       = 11;
  localparam int NOTE_LSB       = 6;
  localparam int DUR_MSB        = 5;
  localparam int DUR_LSB        = 0;
  localparam int HOLD_CNT_MSB   = 6;
  localparam int HOLD_CNT_LSB   = 0;

  localparam int VOICE_W = VOICE_MSB - VOICE_LSB + 1;
  localparam int NOTE_W  = NOTE_MSB - NOTE_LSB + 1;
  localparam int DUR_W   = DUR_MSB - DUR_LSB + 1;
  localparam int HOLD_W  = HOLD_CNT_MSB - HOLD_CNT_LSB + 1;

  // An all-zero word terminates the song
  localparam logic [ENTRY_W-1:0] END_MARKER = 16'h0000;

  typedef logic [ENTRY_W-1:0] entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
    ST_HOLD,
    ST_DONE
  } play_state_t;

  function automatic logic entry_is_hold(input entry_t e);
    return e[ENTRY_HOLD_BIT];
  endfunction

  function automatic logic [VOICE_W-1:0] entry_voice(input entry_t e);
    return e[VOICE_MSB:VOICE_LSB];
  endfunction

  function automatic logic [NOTE_W-1:0] entry_note(input entry_t e);
    return e[NOTE_MSB:NOTE_LSB];
  endfunction

  function automatic logic [DUR_W-1:0] entry_dur(input entry_t e);
    return e[DUR_MSB:DUR_LSB];
  endfunction

  function automatic logic [HOLD_W-1:0] entry_hold_cnt(input entry_t e);
    return e[HOLD_CNT_MSB:HOLD_CNT_LSB];
  endfunction

endpackage

// File: rtl/ram_to_notes_voice_timer.sv
// One playback voice: holds a note for a number of beats, then falls silent.
// A load always beats a concurrent tempo pulse; loading a zero duration
// silences the voice immediately.
module ram_to_notes_voice_timer
  import ram_to_notes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              beat,
  input  logic              load,
  input  logic [NOTE_W-1:0] load_note,
  input  logic [DUR_W-1:0]  load_dur,
  output logic [NOTE_W-1:0] note,
  output logic              active
);

  logic [DUR_W-1:0]  timer_reg;
  logic [NOTE_W-1:0] note_reg;

  // Load / count down the remaining beats; the note clears with the last beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_reg <= '0;
      note_reg  <= '0;
    end else if (load) begin
      timer_reg <= load_dur;
      note_reg  <= (load_dur != '0) ? load_note : '0;
    end else if (beat && (timer_reg != '0)) begin
      timer_reg <= timer_reg - DUR_W'(1);
      if (timer_reg == DUR_W'(1)) begin
        note_reg <= '0;
      end
    end
  end

  assign note   = note_reg;
  assign active = (timer_reg != '0);

endmodule

// File: rtl/ram_to_notes.sv
// Song playback engine: walks the recorded song RAM while master_state is
// PLAY and drives up to NUM_VOICES simultaneous voices to the synth.
// Each entry costs FETCH, WAIT (RAM latency) and DECODE; HOLD entries add
// a beat-counted pause before the next fetch.
// Optional feature macro: RAM_TO_NOTES_LOOP_EN -- when defined, the end of
// the song restarts at address 0 (voices keep sounding) and
// finished_playback pulses for one cycle at each wrap instead of parking in
// DONE.
module ram_to_notes
  import ram_to_notes_pkg::*;
#(
  parameter int LAST_ADDR  = 127,
  parameter int NUM_VOICES = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         beat,
  input  logic [1:0]                   master_state,
  input  logic [ENTRY_W-1:0]           read_data,
  output logic [ADDR_W-1:0]            read_address,
  output logic [NUM_VOICES*NOTE_W-1:0] notes,
  output logic [NUM_VOICES-1:0]        voices_active,
  output logic                         start_playback,
  output logic                         finished_playback
);

  play_state_t       state_reg;
  entry_t            entry_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              play_d_reg;

  logic              ms_play;
  logic              is_hold;
  logic [HOLD_W-1:0] hold_field;
  logic              at_last;
  logic              step_req;
  logic              end_req;
  logic              advance;
  logic              song_end;
  logic              decode_note;
  logic              clear_all;
  logic [NOTE_W-1:0] load_note;
  logic [DUR_W-1:0]  load_dur;
  logic [NUM_VOICES-1:0] voice_load;

  assign ms_play    = (master_state == MS_PLAY);
  assign is_hold    = entry_is_hold(entry_reg);
  assign hold_field = entry_hold_cnt(entry_reg);
  assign at_last    = (read_address == ADDR_W'(LAST_ADDR));

  // Decide whether this cycle moves on to the next entry or ends the song
  always_comb begin
    step_req = 1'b0;
    end_req  = 1'b0;
    case (state_reg)
      ST_DECODE: begin
        if (entry_reg == END_MARKER) begin
          end_req = 1'b1;
        end else if (!(is_hold && (hold_field != '0))) begin
          step_req = 1'b1;
        end
      end
      ST_HOLD: begin
        if (beat && (hold_cnt_reg == HOLD_W'(1))) begin
          step_req = 1'b1;
        end
      end
      default: begin
      end
    endcase
    advance  = step_req & ~at_last;
    song_end = end_req | (step_req & at_last);
  end

  // Sequencer: address walk, entry capture, hold counting and status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= ST_IDLE;
      read_address      <= '0;
      entry_reg         <= '0;
      hold_cnt_reg      <= '0;
      play_d_reg        <= 1'b0;
      start_playback    <= 1'b0;
      finished_playback <= 1'b0;
    end else begin
      play_d_reg        <= ms_play;
      start_playback    <= ms_play & ~play_d_reg;
      finished_playback <= 1'b0;
      if (!ms_play) begin
        // Leaving PLAY from anywhere aborts playback
        state_reg <= ST_IDLE;
      end else if (song_end) begin
`ifdef RAM_TO_NOTES_LOOP_EN
        state_reg    <= ST_FETCH;
        read_address <= '0;
`else
        state_reg    <= ST_DONE;
`endif
        finished_playback <= 1'b1;
      end else if (advance) begin
        read_address <= read_address + ADDR_W'(1);
        state_reg    <= ST_FETCH;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start_playback) begin
              state_reg    <= ST_FETCH;
              read_address <= '0;
            end
          end
          ST_FETCH: begin
            state_reg <= ST_WAIT;
          end
          ST_WAIT: begin
            entry_reg <= read_data;
            state_reg <= ST_DECODE;
          end
          ST_DECODE: begin
            // Only a hold entry with a nonzero count lands here
            hold_cnt_reg <= hold_field;
            state_reg    <= ST_HOLD;
          end
          ST_HOLD: begin
            if (beat) begin
              hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
            end
          end
          ST_DONE: begin
            finished_playback <= 1'b1;
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Outside PLAY every voice is force-loaded with a zero duration (silence)
  assign clear_all   = ~ms_play;
  assign decode_note = ms_play && (state_reg == ST_DECODE) &&
                       (entry_reg != END_MARKER) && !is_hold;
  assign load_note   = clear_all ? '0 : entry_note(entry_reg);
  assign load_dur    = clear_all ? '0 : entry_dur(entry_reg);

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      logic [NOTE_W-1:0] voice_note;
      logic              voice_active;

      assign voice_load[gi] = clear_all |
                              (decode_note &&
                               (entry_voice(entry_reg) == VOICE_W'(gi)));

      ram_to_notes_voice_timer voice_timer (
        .clk       (clk),
        .reset     (reset),
        .beat      (beat),
        .load      (voice_load[gi]),
        .load_note (load_note),
        .load_dur  (load_dur),
        .note      (voice_note),
        .active    (voice_active)
      );

      assign notes[gi*NOTE_W +: NOTE_W] = voice_note;
      assign voices_active[gi]          = voice_active;
    end
  endgenerate

endmodule

// File: tb/tb_ram_to_notes.sv
// Self-checking bench for ram_to_notes: directed songs plus randomized
// songs and beats, compared every cycle against a song-level model.
module tb_ram_to_notes;

  localparam logic [1:0] PLAY = 2'b10;
  localparam logic [1:0] OFF  = 2'b00;

  logic        clk = 1'b0;
  logic        reset;
  logic        beat;
  logic [1:0]  master_state;
  logic [15:0] read_data;
  logic [6:0]  read_address;
  logic [47:0] notes;
  logic [7:0]  voices_active;
  logic        start_playback;
  logic        finished_playback;

  logic [15:0] ram [128];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Synchronous song RAM: data valid one cycle after the address
  always @(posedge clk) read_data <= ram[read_address];

  ram_to_notes dut (
    .clk               (clk),
    .reset             (reset),
    .beat              (beat),
    .master_state      (master_state),
    .read_data         (read_data),
    .read_address      (read_address),
    .notes             (notes),
    .voices_active     (voices_active),
    .start_playback    (start_playback),
    .finished_playback (finished_playback)
  );

  // ---------------- reference model (song level) ----------------
  // m_mode: 0 stopped, 1 walking entries, 2 pausing on a hold, 3 finished
  int m_mode;
  int m_addr;
  int m_dec_in;   // clock edges still to pass before the entry is decoded
  int m_hold;     // beats left in the current pause
  bit m_prev_play;
  bit m_start;
  bit m_fin;
  int m_vn [8];
  int m_vt [8];
  logic last_beat;

  task automatic model_reset();
    m_mode = 0; m_addr = 0; m_dec_in = 0; m_hold = 0;
    m_prev_play = 0; m_start = 0; m_fin = 0;
    for (int v = 0; v < 8; v++) begin
      m_vn[v] = 0;
      m_vt[v] = 0;
    end
  endtask

  task automatic m_finish();
    m_fin = 1;
`ifdef RAM_TO_NOTES_LOOP_EN
    m_addr = 0; m_dec_in = 2; m_mode = 1;
`else
    m_mode = 3;
`endif
  endtask

  task automatic m_next();
    if (m_addr == 127) m_finish();
    else begin
      m_addr++; m_dec_in = 2; m_mode = 1;
    end
  endtask

  task automatic m_decode();
    logic [15:0] e;
    int v, d;
    e = ram[m_addr];
    if (e == 16'h0000) m_finish();
    else if (e[15]) begin
      if (e[6:0] == 7'd0) m_next();
      else begin
        m_mode = 2; m_hold = int'(e[6:0]);
      end
    end else begin
      v = int'(e[14:12]);
      d = int'(e[5:0]);
      m_vt[v] = d;
      m_vn[v] = (d != 0) ? int'(e[11:6]) : 0;
      m_next();
    end
  endtask

  // Advance the model across one clock edge given the inputs seen at it
  task automatic model_step(input logic b, input logic [1:0] ms);
    bit play, old_start;
    play      = (ms == PLAY);
    old_start = m_start;
    m_start   = play && !m_prev_play;
    m_prev_play = play;
    m_fin = 0;
    if (!play) begin
      m_mode = 0;
      for (int v = 0; v < 8; v++) begin
        m_vn[v] = 0; m_vt[v] = 0;
      end
    end else begin
      if (b) begin
        for (int v = 0; v < 8; v++) begin
          if (m_vt[v] > 0) begin
            m_vt[v]--;
            if (m_vt[v] == 0) m_vn[v] = 0;
          end
        end
      end
      case (m_mode)
        0: if (old_start) begin
             m_mode = 1; m_addr = 0; m_dec_in = 2;
           end
        1: if (m_dec_in > 0) m_dec_in--;
           else m_decode();
        2: if (b) begin
             m_hold--;
             if (m_hold == 0) m_next();
           end
        default: m_fin = 1;
      endcase
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [47:0] en;
    logic [7:0]  ea;
    for (int v = 0; v < 8; v++) begin
      en[6*v +: 6] = 6'(m_vn[v]);
      ea[v]        = (m_vt[v] > 0);
    end
    check("notes", 64'(notes), 64'(en));
    check("voices_active", 64'(voices_active), 64'(ea));
    check("read_address", 64'(read_address), 64'(m_addr));
    check("start_playback", 64'(start_playback), 64'(m_start));
    check("finished_playback", 64'(finished_playback), 64'(m_fin));
  endtask

  // bmode 0: sparse random beats, 1: beat every cycle, 2: no beats
  task automatic cycle(input int bmode, input logic [1:0] ms);
    logic b;
    case (bmode)
      0:       b = !last_beat && ($urandom_range(0, 2) == 0);
      1:       b = 1'b1;
      default: b = 1'b0;
    endcase
    last_beat    = b;
    beat         = b;
    master_state = ms;
    @(posedge clk);
    model_step(b, ms);
    #1;
    compare_all();
  endtask

  task automatic run(input int n, input int bmode, input logic [1:0] ms);
    repeat (n) cycle(bmode, ms);
  endtask

  function automatic logic [15:0] mk_note(input int v, input int n, input int d);
    return {1'b0, 3'(v), 6'(n), 6'(d)};
  endfunction

  function automatic logic [15:0] mk_hold(input int n);
    return {1'b1, 8'h00, 7'(n)};
  endfunction

  task automatic clear_ram();
    for (int i = 0; i < 128; i++) ram[i] = 16'h0000;
  endtask

  task automatic note_done(input string name);
    $display("transaction %-22s checks=%0d errors=%0d", name, checks, errors);
  endtask

  initial begin
    reset = 1'b0; beat = 1'b0; master_state = OFF; last_beat = 1'b0;
    clear_ram();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_notes", 64'(notes), 64'd0);
    check("reset_active", 64'(voices_active), 64'd0);
    check("reset_addr", 64'(read_address), 64'd0);
    check("reset_start", 64'(start_playback), 64'd0);
    check("reset_finished", 64'(finished_playback), 64'd0);
    reset = 1'b1;
    note_done("reset");

    // Single note then end marker
    ram[0] = 16'h0103; ram[1] = 16'h0000;
    run(3, 0, OFF); run(40, 0, PLAY); run(3, 0, OFF);
    note_done("single_note");

    // Note, hold 4 beats, note, end
    clear_ram();
    ram[0] = mk_note(2, 9, 2); ram[1] = mk_hold(4);
    ram[2] = mk_note(5, 1, 1); ram[3] = 16'h0000;
    run(60, 0, PLAY); run(3, 0, OFF);
    note_done("hold_then_note");

    // Retrigger of voice 3 on a beat cycle
    clear_ram();
    ram[0] = mk_note(3, 7, 5); ram[1] = mk_note(3, 9, 5);
    ram[2] = mk_hold(2); ram[3] = 16'h0000;
    run(30, 1, PLAY); run(3, 2, OFF);
    note_done("retrigger_on_beat");

    // Abort while pausing, then restart from address 0
    clear_ram();
    ram[0] = mk_note(1, 3, 20); ram[1] = mk_note(4, 6, 20);
    ram[2] = mk_hold(30); ram[3] = 16'h0000;
    run(14, 2, PLAY); run(4, 0, OFF); run(20, 0, PLAY); run(3, 0, OFF);
    note_done("abort_in_hold");

    // Full RAM of note entries: runs to the last address
    for (int i = 0; i < 128; i++)
      ram[i] = mk_note($urandom_range(1, 7), $urandom_range(0, 63), $urandom_range(1, 63));
    run(430, 0, PLAY); run(3, 0, OFF);
    note_done("full_ram");

    // Random songs with random beats and occasional early abort
    for (int s = 0; s < 6; s++) begin
      int len;
      clear_ram();
      len = $urandom_range(3, 20);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) ram[i] = mk_hold($urandom_range(0, 5));
        else ram[i] = mk_note($urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 8));
      end
      run($urandom_range(30, 160), 0, PLAY);
      run(3, 0, OFF);
      note_done("random_song");
    end

    // Asynchronous reset with three voices sounding
    clear_ram();
    ram[0] = mk_note(0, 11, 40); ram[1] = mk_note(1, 12, 40);
    ram[2] = mk_note(2, 13, 40); ram[3] = mk_hold(60);
    run(16, 2, PLAY);
    check("three_voices", 64'($countones(voices_active)), 64'd3);
    #2 reset = 1'b0;
    #1;
    check("async_notes", 64'(notes), 64'd0);
    check("async_active", 64'(voices_active), 64'd0);
    check("async_addr", 64'(read_address), 64'd0);
    check("async_finished", 64'(finished_playback), 64'd0);
    @(posedge clk);
    #1;
    check("async_hold_active", 64'(voices_active), 64'd0);
    master_state = OFF;
    reset = 1'b1;
    model_reset();
    run(5, 0, OFF);
    note_done("async_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
